bp_cce_mem_arbiter: RTL and testbench

Merges the CCE-MEM BedRock Stream command channels of `num_cce_p` CCE instances onto one memory port, and routes the in-order memory responses back to the CCE that issued each command. It sits between a multi-slice CCE tile (N `bp_cce_wrapper`-class instances) and the memory-side network. It arbitrates per stream, never per beat, and supports round-robin or fixed-priority arbitration. An order FIFO tracks outstanding commands.

---
 rtl/bp_cce_mem_arbiter_pkg.sv | 40 ++++
 rtl/bp_cce_mem_arbiter_if.sv | 50 +++++
 rtl/bp_cce_mem_arbiter_order_fifo.sv | 46 ++++
 rtl/bp_cce_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_bp_cce_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_cce_mem_arbiter_pkg.sv
// Shared types for the CCE-to-memory arbiter: BedRock memory header layout, FSM and arbitration encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_me_pkg;

  // Processor configuration used by the memory interface.
  localparam int paddr_width_p        = 40;
  localparam int did_width_p          = 4;
  localparam int lce_id_width_p       = 4;
  localparam int lce_assoc_p          = 8;
  localparam int bedrock_data_width_p = 64;
  localparam int lce_way_width_lp     = $clog2(lce_assoc_p);

  typedef struct packed {
    logic [did_width_p-1:0]      did;
    logic [lce_id_width_p-1:0]   lce_id;
    logic [lce_way_width_lp-1:0] way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s  payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               subop;
    logic [3:0]               msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic {
    e_idle   = 1'b0,
    e_stream = 1'b1
  } bp_cce_mem_arb_state_e;

  typedef enum logic {
    e_arb_rr    = 1'b0,
    e_arb_fixed = 1'b1
  } bp_cce_mem_arb_mode_e;

endpackage

// File: rtl/bp_cce_mem_arbiter_if.sv
// Bundle of the per-CCE command/response streams and the single memory-side port.
// Latency: n/a (wires only).
// Backpressure: valid/ready_and on every stream; slave modport is the arbiter side.
interface bp_cce_mem_arbiter_if
  import bp_me_pkg::*;
 #(parameter int num_cce_p = 2);

  // CCE side
  logic [num_cce_p*mem_header_width_lp-1:0]  cce_cmd_header_i;
  logic [num_cce_p*bedrock_data_width_p-1:0] cce_cmd_data_i;
  logic [num_cce_p-1:0]                      cce_cmd_v_i;
  logic [num_cce_p-1:0]                      cce_cmd_ready_and_o;
  logic [num_cce_p-1:0]                      cce_cmd_last_i;
  logic [num_cce_p*mem_header_width_lp-1:0]  cce_resp_header_o;
  logic [num_cce_p*bedrock_data_width_p-1:0] cce_resp_data_o;
  logic [num_cce_p-1:0]                      cce_resp_v_o;
  logic [num_cce_p-1:0]                      cce_resp_ready_and_i;
  logic [num_cce_p-1:0]                      cce_resp_last_o;

  // Memory side
  logic [mem_header_width_lp-1:0]  mem_cmd_header_o;
  logic [bedrock_data_width_p-1:0] mem_cmd_data_o;
  logic                            mem_cmd_v_o;
  logic                            mem_cmd_ready_and_i;
  logic                            mem_cmd_last_o;
  logic [mem_header_width_lp-1:0]  mem_resp_header_i;
  logic [bedrock_data_width_p-1:0] mem_resp_data_i;
  logic                            mem_resp_v_i;
  logic                            mem_resp_ready_and_o;
  logic                            mem_resp_last_i;

  modport slave (
    input  cce_cmd_header_i, cce_cmd_data_i, cce_cmd_v_i, cce_cmd_last_i,
           cce_resp_ready_and_i, mem_cmd_ready_and_i,
           mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i,
    output cce_cmd_ready_and_o, cce_resp_header_o, cce_resp_data_o, cce_resp_v_o,
           cce_resp_last_o, mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o,
           mem_cmd_last_o, mem_resp_ready_and_o
  );

  modport master (
    output cce_cmd_header_i, cce_cmd_data_i, cce_cmd_v_i, cce_cmd_last_i,
           cce_resp_ready_and_i, mem_cmd_ready_and_i,
           mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i,
    input  cce_cmd_ready_and_o, cce_resp_header_o, cce_resp_data_o, cce_resp_v_o,
           cce_resp_last_o, mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o,
           mem_cmd_last_o, mem_resp_ready_and_o
  );

endinterface

// File: rtl/bp_cce_mem_arbiter_order_fifo.sv
// Order FIFO remembering which CCE issued each outstanding memory command.
// Latency: 1 cycle from enqueue to visibility at the head.
// Backpressure: full blocks enqueue (full is the registered value, no same-cycle bypass); empty blocks dequeue.
module bp_cce_mem_order_fifo
 #(parameter int width_p = 1,
   parameter int els_p   = 4)
  (input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               enq_i,
   input  logic [width_p-1:0] data_i,
   input  logic               deq_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o);

  localparam int ptr_width_lp = $clog2(els_p);

  // Extra MSB on each pointer is the wrap bit distinguishing full from empty.
  logic [ptr_width_lp:0]   wptr_q, rptr_q;
  logic [width_p-1:0]      mem_q [els_p];
  logic                    enq_ok, deq_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
                && (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);
  assign enq_ok  = enq_i & ~full_o;
  assign deq_ok  = deq_i & ~empty_o;
  assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (enq_ok) wptr_q <= wptr_q + 1'b1;
      if (deq_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_cce_mem_arbiter.sv
// Merges N CCE command streams onto one memory port (per-stream grant) and routes in-order responses back.
// Latency: 0 cycles command mux; response routing valid the cycle after the command enqueue.
// Backpressure: ready_and passes through to the granted CCE only; order FIFO full stalls new grants; empty stalls responses.
module bp_cce_mem_arbiter
  import bp_me_pkg::*;
 #(parameter int num_cce_p   = 2,
   parameter int arb_mode_p  = 0,
   parameter int order_els_p = 4)
  (input  logic                  clk_i,
   input  logic                  reset_n_i,
   bp_cce_mem_arbiter_if.slave   io);

  localparam int cce_sel_width_lp = (num_cce_p == 1) ? 1 : $clog2(num_cce_p);
  typedef logic [cce_sel_width_lp-1:0] cce_sel_t;
  localparam cce_sel_t last_cce_lp = cce_sel_t'(num_cce_p - 1);

  bp_cce_mem_arb_state_e state_q, state_d;
  cce_sel_t              grant_q, grant_d;
  cce_sel_t              rr_ptr_q, rr_ptr_d;
  cce_sel_t              winner, sel, resp_dst;
  logic                  winner_v, cmd_active, cmd_v, cmd_last, cmd_hs, enq;
  logic                  fifo_full, fifo_empty, resp_v, resp_rdy, resp_deq;
  int                    idx;

  // Combinational arbitration: round-robin search from the pointer, or lowest index first.
  always_comb begin
    winner   = '0;
    winner_v = 1'b0;
    idx      = 0;
    for (int k = 0; k < num_cce_p; k++) begin
      if (arb_mode_p == int'(e_arb_fixed)) idx = k;
      else                                 idx = (int'(rr_ptr_q) + k) % num_cce_p;
      if (!winner_v && io.cce_cmd_v_i[idx]) begin
        winner_v = 1'b1;
        winner   = cce_sel_t'(idx);
      end
    end
  end

  // Command FSM next state, grant lock, pointer advance and enqueue decision.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    enq        = 1'b0;
    sel        = winner;
    cmd_active = winner_v & ~fifo_full;
    if (state_q == e_stream) begin
      sel        = grant_q;
      cmd_active = io.cce_cmd_v_i[grant_q];
    end
    // Reset forces every valid/ready low immediately, independent of inputs.
    cmd_v    = reset_n_i & cmd_active;
    cmd_last = io.cce_cmd_last_i[sel];
    cmd_hs   = cmd_v & io.mem_cmd_ready_and_i;
    case (state_q)
      e_idle: begin
        if (cmd_hs) begin
          enq = 1'b1;
          if (!cmd_last) begin
            state_d = e_stream;
            grant_d = winner;
          end
        end
      end
      e_stream: begin
        if (cmd_hs && cmd_last) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
    if ((arb_mode_p == int'(e_arb_rr)) && cmd_hs && cmd_last)
      rr_ptr_d = (sel == last_cce_lp) ? '0 : cce_sel_t'(sel + 1'b1);
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign io.mem_cmd_v_o      = cmd_v;
  assign io.mem_cmd_last_o   = cmd_last;
  assign io.mem_cmd_header_o = io.cce_cmd_header_i[sel*mem_header_width_lp +: mem_header_width_lp];
  assign io.mem_cmd_data_o   = io.cce_cmd_data_i[sel*bedrock_data_width_p +: bedrock_data_width_p];

  bp_cce_mem_order_fifo
   #(.width_p(cce_sel_width_lp), .els_p(order_els_p))
   order_fifo
    (.clk_i     (clk_i),
     .reset_n_i (reset_n_i),
     .enq_i     (enq),
     .data_i    (winner),
     .deq_i     (resp_deq),
     .data_o    (resp_dst),
     .full_o    (fifo_full),
     .empty_o   (fifo_empty));

  assign resp_v   = io.mem_resp_v_i & ~fifo_empty;
  assign resp_rdy = io.cce_resp_ready_and_i[resp_dst] & ~fifo_empty;
  assign resp_deq = io.mem_resp_v_i & resp_rdy & io.mem_resp_last_i;

  assign io.mem_resp_ready_and_o = resp_rdy;
  assign io.cce_resp_header_o    = {num_cce_p{io.mem_resp_header_i}};
  assign io.cce_resp_data_o      = {num_cce_p{io.mem_resp_data_i}};
  assign io.cce_resp_last_o      = {num_cce_p{io.mem_resp_last_i}};

  for (genvar i = 0; i < num_cce_p; i++) begin : g_cce
    assign io.cce_cmd_ready_and_o[i] = cmd_v & io.mem_cmd_ready_and_i & (sel == cce_sel_t'(i));
    assign io.cce_resp_v_o[i]        = resp_v & (resp_dst == cce_sel_t'(i));
  end

  // A response with nothing outstanding means memory broke command ordering.
  resp_without_cmd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                     !(io.mem_resp_v_i && fifo_empty));

endmodule

// File: tb/tb_bp_cce_mem_arbiter.sv
module tb_bp_cce_mem_arbiter;
  import bp_me_pkg::*;

  localparam int HW = mem_header_width_lp;
  localparam int DW = bedrock_data_width_p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_cce_mem_arbiter_if #(.num_cce_p(2)) ifa ();
  bp_cce_mem_arbiter_if #(.num_cce_p(4)) ifb ();

  bp_cce_mem_arbiter #(.num_cce_p(2), .arb_mode_p(0), .order_els_p(4)) dut_a
    (.clk_i(clk), .reset_n_i(rst_n), .io(ifa));
  bp_cce_mem_arbiter #(.num_cce_p(4), .arb_mode_p(1), .order_els_p(4)) dut_b
    (.clk_i(clk), .reset_n_i(rst_n), .io(ifb));

  int n_cmp = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];
  int rr_exp = 0;

  function automatic bp_bedrock_mem_header_s mk_hdr(input int cce, input int seq);
    bp_bedrock_mem_header_s h;
    h = '0;
    h.msg_type       = 4'h2;
    h.addr           = paddr_width_p'((cce << 12) | (seq << 6));
    h.payload.lce_id = lce_id_width_p'(cce);
    h.payload.did    = did_width_p'(seq);
    return h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd_a(input logic [1:0] v, input logic [1:0] last, input int seq);
    for (int i = 0; i < 2; i++) begin
      ifa.cce_cmd_header_i[i*HW +: HW] = mk_hdr(i, seq);
      ifa.cce_cmd_data_i[i*DW +: DW]   = DW'(i*256 + seq);
    end
    ifa.cce_cmd_v_i    = v;
    ifa.cce_cmd_last_i = last;
  endtask

  task automatic set_cmd_b(input logic [3:0] v, input logic [3:0] last, input int seq);
    for (int i = 0; i < 4; i++) begin
      ifb.cce_cmd_header_i[i*HW +: HW] = mk_hdr(i, seq);
      ifb.cce_cmd_data_i[i*DW +: DW]   = DW'(i*256 + seq);
    end
    ifb.cce_cmd_v_i    = v;
    ifb.cce_cmd_last_i = last;
  endtask

  task automatic test_reset();
    set_cmd_a(2'b11, 2'b11, 0);
    set_cmd_b(4'hf, 4'hf, 0);
    ifa.mem_cmd_ready_and_i = 1'b1;  ifb.mem_cmd_ready_and_i = 1'b1;
    ifa.cce_resp_ready_and_i = 2'b11; ifb.cce_resp_ready_and_i = 4'hf;
    ifa.mem_resp_v_i = 1'b0; ifb.mem_resp_v_i = 1'b0;
    ifa.mem_resp_last_i = 1'b1; ifb.mem_resp_last_i = 1'b1;
    ifa.mem_resp_header_i = '0; ifb.mem_resp_header_i = '0;
    ifa.mem_resp_data_i = '0; ifb.mem_resp_data_i = '0;
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    n_cmp++; if (ifa.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL reset_a_mem_cmd_v: got %b want 0", ifa.mem_cmd_v_o); end
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b00) begin n_err++; $display("FAIL reset_a_cmd_ready: got %b want 00", ifa.cce_cmd_ready_and_o); end
    n_cmp++; if (ifa.cce_resp_v_o !== 2'b00) begin n_err++; $display("FAIL reset_a_resp_v: got %b want 00", ifa.cce_resp_v_o); end
    n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b0) begin n_err++; $display("FAIL reset_a_resp_ready: got %b want 0", ifa.mem_resp_ready_and_o); end
    n_cmp++; if (ifb.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL reset_b_mem_cmd_v: got %b want 0", ifb.mem_cmd_v_o); end
    n_cmp++; if (ifb.cce_cmd_ready_and_o !== 4'h0) begin n_err++; $display("FAIL reset_b_cmd_ready: got %b want 0000", ifb.cce_cmd_ready_and_o); end
    step();
    set_cmd_a(2'b00, 2'b00, 0);
    set_cmd_b(4'h0, 4'h0, 0);
    rst_n = 1'b1;
    rr_exp = 0;
  endtask

  task automatic test_rr_alternate();
    int e;
    int d;
    bp_bedrock_mem_header_s eh;
    for (int k = 0; k < 4; k++) begin
      set_cmd_a(2'b11, 2'b11, k);
      @(negedge clk);
      e  = rr_exp;
      eh = mk_hdr(e, k);
      n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'(1 << e)) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, ifa.cce_cmd_ready_and_o, 2'(1 << e)); end
      n_cmp++; if (ifa.mem_cmd_header_o !== eh) begin n_err++; $display("FAIL rr_header[%0d]: got %h want %h", k, ifa.mem_cmd_header_o, eh); end
      qa.push_back(e);
      rr_exp = (e + 1) % 2;
      step();
    end
    @(negedge clk);
    n_cmp++; if (ifa.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rr_full_cmd_v: got %b want 0", ifa.mem_cmd_v_o); end
    step();
    set_cmd_a(2'b00, 2'b00, 0);
    for (int r = 0; r < 8 && qa.size() > 0; r++) begin
      ifa.mem_resp_header_i = mk_hdr(7, r);
      ifa.mem_resp_v_i = 1'b1;
      ifa.mem_resp_last_i = 1'b1;
      @(negedge clk);
      d  = qa.pop_front();
      eh = mk_hdr(7, r);
      n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL rr_resp_v[%0d]: got %b want %b", r, ifa.cce_resp_v_o, 2'(1 << d)); end
      n_cmp++; if (ifa.cce_resp_header_o[d*HW +: HW] !== eh) begin n_err++; $display("FAIL rr_resp_hdr[%0d]: got %h want %h", r, ifa.cce_resp_header_o[d*HW +: HW], eh); end
      step();
    end
    ifa.mem_resp_v_i = 1'b0;
  endtask

  task automatic test_order_full();
    int d;
    for (int k = 0; k < 4; k++) begin
      set_cmd_a(2'b10, 2'b10, 10 + k);
      @(negedge clk);
      n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b10) begin n_err++; $display("FAIL full_fill_ready[%0d]: got %b want 10", k, ifa.cce_cmd_ready_and_o); end
      qa.push_back(1);
      rr_exp = 0;
      step();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b00) begin n_err++; $display("FAIL full_stall_ready[%0d]: got %b want 00", k, ifa.cce_cmd_ready_and_o); end
      step();
    end
    ifa.mem_resp_header_i = mk_hdr(7, 50);
    ifa.mem_resp_v_i = 1'b1;
    ifa.mem_resp_last_i = 1'b1;
    @(negedge clk);
    d = qa.pop_front();
    n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL full_resp_v: got %b want %b", ifa.cce_resp_v_o, 2'(1 << d)); end
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b00) begin n_err++; $display("FAIL full_no_bypass: got %b want 00", ifa.cce_cmd_ready_and_o); end
    step();
    ifa.mem_resp_v_i = 1'b0;
    set_cmd_a(2'b10, 2'b10, 14);
    @(negedge clk);
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b10) begin n_err++; $display("FAIL full_freed_ready: got %b want 10", ifa.cce_cmd_ready_and_o); end
    qa.push_back(1);
    step();
    set_cmd_a(2'b00, 2'b00, 0);
    for (int r = 0; r < 8 && qa.size() > 0; r++) begin
      ifa.mem_resp_v_i = 1'b1;
      @(negedge clk);
      d = qa.pop_front();
      n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL full_drain_v[%0d]: got %b want %b", r, ifa.cce_resp_v_o, 2'(1 << d)); end
      step();
    end
    ifa.mem_resp_v_i = 1'b0;
    n_cmp++; if (qa.size() != 0) begin n_err++; $display("FAIL full_drain_left: got %0d want 0", qa.size()); end
  endtask

  task automatic test_stream_lock();
    bp_bedrock_mem_header_s eh;
    for (int b = 0; b < 4; b++) begin
      if (b == 0)      set_cmd_a(2'b10, 2'b00, 20 + b);
      else if (b < 3)  set_cmd_a(2'b11, 2'b00, 20 + b);
      else             set_cmd_a(2'b11, 2'b11, 20 + b);
      @(negedge clk);
      eh = mk_hdr(1, 20 + b);
      n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b10) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 10", b, ifa.cce_cmd_ready_and_o); end
      n_cmp++; if (ifa.mem_cmd_header_o !== eh) begin n_err++; $display("FAIL stream_hdr[%0d]: got %h want %h", b, ifa.mem_cmd_header_o, eh); end
      if (b == 0) qa.push_back(1);
      step();
    end
    rr_exp = 0;
    set_cmd_a(2'b01, 2'b01, 24);
    @(negedge clk);
    eh = mk_hdr(0, 24);
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b01) begin n_err++; $display("FAIL stream_next_ready: got %b want 01", ifa.cce_cmd_ready_and_o); end
    n_cmp++; if (ifa.mem_cmd_header_o !== eh) begin n_err++; $display("FAIL stream_next_hdr: got %h want %h", ifa.mem_cmd_header_o, eh); end
    qa.push_back(0);
    rr_exp = 1;
    step();
    set_cmd_a(2'b00, 2'b00, 0);
  endtask

  task automatic test_resp_backpressure();
    int d;
    d = qa[0];
    ifa.mem_resp_header_i = mk_hdr(7, 40);
    ifa.mem_resp_v_i = 1'b1;
    ifa.mem_resp_last_i = 1'b0;
    ifa.cce_resp_ready_and_i = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", c, ifa.mem_resp_ready_and_o); end
      n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL bp_stall_v[%0d]: got %b want %b", c, ifa.cce_resp_v_o, 2'(1 << d)); end
      step();
    end
    ifa.cce_resp_ready_and_i = 2'b11;
    for (int bt = 0; bt < 2; bt++) begin
      ifa.mem_resp_last_i = (bt == 1);
      @(negedge clk);
      n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b1) begin n_err++; $display("FAIL bp_beat_ready[%0d]: got %b want 1", bt, ifa.mem_resp_ready_and_o); end
      n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL bp_beat_v[%0d]: got %b want %b", bt, ifa.cce_resp_v_o, 2'(1 << d)); end
      step();
    end
    void'(qa.pop_front());
    d = qa.pop_front();
    @(negedge clk);
    n_cmp++; if (ifa.cce_resp_v_o !== 2'(1 << d)) begin n_err++; $display("FAIL bp_second_v: got %b want %b", ifa.cce_resp_v_o, 2'(1 << d)); end
    step();
    ifa.mem_resp_v_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b0) begin n_err++; $display("FAIL bp_empty_ready: got %b want 0", ifa.mem_resp_ready_and_o); end
    step();
  endtask

  task automatic test_fixed_priority();
    int d;
    logic [3:0] er;
    int starve = 0;
    for (int k = 0; k < 5; k++) begin
      set_cmd_b(4'hf, 4'hf, 60 + k);
      @(negedge clk);
      er = (qb.size() < 4) ? 4'b0001 : 4'b0000;
      n_cmp++; if (ifb.cce_cmd_ready_and_o !== er) begin n_err++; $display("FAIL fixed_fill_ready[%0d]: got %b want %b", k, ifb.cce_cmd_ready_and_o, er); end
      if (er != 4'b0000) qb.push_back(0);
      step();
    end
    ifb.mem_resp_v_i = 1'b1;
    ifb.mem_resp_last_i = 1'b1;
    for (int r = 0; r < 6; r++) begin
      set_cmd_b(4'hf, 4'hf, 70 + r);
      @(negedge clk);
      er = (qb.size() < 4) ? 4'b0001 : 4'b0000;
      d  = qb.pop_front();
      if (ifb.cce_cmd_ready_and_o[3]) starve++;
      n_cmp++; if (ifb.cce_cmd_ready_and_o !== er) begin n_err++; $display("FAIL fixed_run_ready[%0d]: got %b want %b", r, ifb.cce_cmd_ready_and_o, er); end
      n_cmp++; if (ifb.cce_resp_v_o !== 4'(1 << d)) begin n_err++; $display("FAIL fixed_run_resp_v[%0d]: got %b want %b", r, ifb.cce_resp_v_o, 4'(1 << d)); end
      if (er != 4'b0000) qb.push_back(0);
      step();
    end
    n_cmp++; if (starve != 0) begin n_err++; $display("FAIL fixed_cce3_granted: got %0d want 0", starve); end
    set_cmd_b(4'h0, 4'h0, 0);
    for (int r = 0; r < 8 && qb.size() > 0; r++) begin
      @(negedge clk);
      d = qb.pop_front();
      n_cmp++; if (ifb.cce_resp_v_o !== 4'(1 << d)) begin n_err++; $display("FAIL fixed_drain_v[%0d]: got %b want %b", r, ifb.cce_resp_v_o, 4'(1 << d)); end
      step();
    end
    ifb.mem_resp_v_i = 1'b0;
    n_cmp++; if (qb.size() != 0) begin n_err++; $display("FAIL fixed_drain_left: got %0d want 0", qb.size()); end
  endtask

  task automatic test_reset_mid();
    // Pointer sits at 1 here, so CCE1 wins and starts a multi-beat stream.
    set_cmd_a(2'b10, 2'b00, 80);
    @(negedge clk);
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'(1 << rr_exp)) begin n_err++; $display("FAIL rstmid_start_ready: got %b want %b", ifa.cce_cmd_ready_and_o, 2'(1 << rr_exp)); end
    step();
    set_cmd_a(2'b11, 2'b00, 81);
    ifa.cce_resp_ready_and_i = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ifa.mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rstmid_cmd_v: got %b want 0", ifa.mem_cmd_v_o); end
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b00) begin n_err++; $display("FAIL rstmid_cmd_ready: got %b want 00", ifa.cce_cmd_ready_and_o); end
    n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b0) begin n_err++; $display("FAIL rstmid_resp_ready: got %b want 0", ifa.mem_resp_ready_and_o); end
    step();
    #2;
    set_cmd_a(2'b11, 2'b11, 82);
    rst_n = 1'b1;
    qa.delete();
    rr_exp = 0;
    @(negedge clk);
    n_cmp++; if (ifa.mem_resp_ready_and_o !== 1'b0) begin n_err++; $display("FAIL rstmid_fifo_empty: got %b want 0", ifa.mem_resp_ready_and_o); end
    n_cmp++; if (ifa.cce_cmd_ready_and_o !== 2'b01) begin n_err++; $display("FAIL rstmid_ptr_cleared: got %b want 01", ifa.cce_cmd_ready_and_o); end
    step();
    set_cmd_a(2'b00, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_order_full();
    test_stream_lock();
    test_resp_backpressure();
    test_fixed_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
